// File: rtl/megacart_pkg.sv
// Shared constants, FSM state type and window helper for the MegaCart NVRAM path.
package megacart_pkg;

  localparam int unsigned FILE_AW   = 13;
  localparam int unsigned REGION_AW = 16;
  localparam int unsigned MEM_AW    = 23;
  localparam int unsigned TIMER_W   = 24;

  localparam logic [MEM_AW-1:0]    NVRAM_BASE      = 23'h400000;

  localparam logic [FILE_AW-1:0]   FILE_LO_START   = 13'h0400;
  localparam logic [FILE_AW-1:0]   FILE_LO_END     = 13'h0FFF;
  localparam logic [REGION_AW-1:0] REGION_LO_START = 16'h0400;
  localparam logic [FILE_AW-1:0]   FILE_HI_START   = 13'h1800;
  localparam logic [FILE_AW-1:0]   FILE_HI_END     = 13'h1FFF;
  localparam logic [REGION_AW-1:0] REGION_HI_START = 16'h9800;

  localparam logic [FILE_AW-1:0]   FILE_LAST       = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WR,
    SAVE_RD,
    SAVE_OUT
  } nv_state_e;

  // Wrapping subtract keeps the test valid for a window ending at the top of the file.
  function automatic logic in_window(input logic [FILE_AW-1:0] off,
                                     input logic [FILE_AW-1:0] lo,
                                     input logic [FILE_AW-1:0] hi);
    return FILE_AW'(off - lo) <= FILE_AW'(hi - lo);
  endfunction

endpackage

// File: rtl/megacart_nvram_map.sv
// Combinational file offset -> {backed, SDRAM region offset} unmangler.
module megacart_nvram_map
  import megacart_pkg::*;
(
  input  logic [FILE_AW-1:0]   off,
  output logic                 backed_c,
  output logic [REGION_AW-1:0] region_c
);

  always_comb begin
    backed_c = 1'b0;
    region_c = '0;
    if (in_window(off, FILE_LO_START, FILE_LO_END)) begin
      backed_c = 1'b1;
      region_c = REGION_LO_START + REGION_AW'(FILE_AW'(off - FILE_LO_START));
    end else if (in_window(off, FILE_HI_START, FILE_HI_END)) begin
      backed_c = 1'b1;
      region_c = REGION_HI_START + REGION_AW'(FILE_AW'(off - FILE_HI_START));
    end
  end

endmodule

// File: rtl/megacart_nvram_io.sv
// Streams the MegaCart NVRAM image between the host ioctl byte stream and SDRAM.
// Optional autosave tracking is compiled in with MEGACART_NVRAM_AUTOSAVE_EN.
module megacart_nvram_io
  import megacart_pkg::*;
#(
  parameter logic [7:0]         FILL_BYTE   = 8'hFF,
  parameter logic [TIMER_W-1:0] IDLE_CYCLES = 24'd8000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_active,
  input  logic               load_wr,
  input  logic [FILE_AW-1:0] load_addr,
  input  logic [7:0]         load_data,
  output logic               load_busy,
  input  logic               save_start,
  output logic               save_valid,
  input  logic               save_ready,
  output logic [FILE_AW-1:0] save_addr,
  output logic [7:0]         save_data,
  output logic               save_done,
  output logic               mem_req,
  output logic               mem_we,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  input  logic               nv_wr,
  output logic               autosave_req,
  output logic               dirty
);

  nv_state_e            state, state_n;
  logic [FILE_AW-1:0]   off, off_n;
  logic [7:0]           save_data_n;
  logic                 save_done_n;
  logic                 load_take;
  logic                 map_backed_c;
  logic [REGION_AW-1:0] map_region_c;

  // Map the offset the FSM is moving to, so mem_* register alongside the state.
  megacart_nvram_map u_map (
    .off      (off_n),
    .backed_c (map_backed_c),
    .region_c (map_region_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      off   <= '0;
    end else begin
      state <= state_n;
      off   <= off_n;
    end
  end

  // In the access states mem_req doubles as the registered "offset is backed" flag.
  always_comb begin
    state_n     = state;
    off_n       = off;
    save_data_n = save_data;
    save_done_n = 1'b0;
    load_take   = 1'b0;
    case (state)
      IDLE: begin
        if (load_wr) begin
          state_n   = LOAD_WR;
          off_n     = load_addr;
          load_take = 1'b1;
        end else if (save_start) begin
          state_n = SAVE_RD;
          off_n   = '0;
        end
      end
      LOAD_WR: begin
        if (!mem_req || mem_ack) state_n = IDLE;
      end
      SAVE_RD: begin
        if (!mem_req) begin
          save_data_n = FILL_BYTE;
          state_n     = SAVE_OUT;
        end else if (mem_ack) begin
          save_data_n = mem_rdata;
          state_n     = SAVE_OUT;
        end
      end
      SAVE_OUT: begin
        if (save_ready) begin
          if (off == FILE_LAST) begin
            save_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            off_n   = off + FILE_AW'(1);
            state_n = SAVE_RD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_busy  <= 1'b0;
      save_valid <= 1'b0;
      save_addr  <= '0;
      save_data  <= '0;
      save_done  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      load_busy  <= (state_n == LOAD_WR);
      save_valid <= (state_n == SAVE_OUT);
      save_addr  <= off_n;
      save_data  <= save_data_n;
      save_done  <= save_done_n;
      mem_req    <= map_backed_c && ((state_n == LOAD_WR) || (state_n == SAVE_RD));
      mem_we     <= map_backed_c && (state_n == LOAD_WR);
      mem_addr   <= NVRAM_BASE | MEM_AW'(map_region_c);
      if (load_take) mem_wdata <= load_data;
    end
  end

`ifdef MEGACART_NVRAM_AUTOSAVE_EN
  logic               load_active_q;
  logic [TIMER_W-1:0] idle_timer;

  // CPU writes win over clears landing in the same cycle so no modification is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_active_q <= 1'b0;
      idle_timer    <= '0;
      dirty         <= 1'b0;
      autosave_req  <= 1'b0;
    end else begin
      load_active_q <= load_active;
      autosave_req  <= 1'b0;
      if (nv_wr) begin
        dirty      <= 1'b1;
        idle_timer <= IDLE_CYCLES;
      end else if (load_active_q && !load_active) begin
        dirty      <= 1'b0;
        idle_timer <= '0;
      end else begin
        if (save_done_n) dirty <= 1'b0;
        if (dirty && (state == IDLE) && (idle_timer != '0)) begin
          idle_timer <= idle_timer - TIMER_W'(1);
          if (idle_timer == TIMER_W'(1)) autosave_req <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_autosave;
  assign unused_autosave = &{1'b0, load_active, nv_wr, IDLE_CYCLES};
  assign dirty           = 1'b0;
  assign autosave_req    = 1'b0;
`endif

endmodule

// File: tb/tb_megacart_nvram_io.sv
// Self-checking bench for megacart_nvram_io: SDRAM responder plus file-offset image model.
module tb_megacart_nvram_io;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_active, load_wr, save_start, save_ready, nv_wr, mem_ack;
  logic [12:0] load_addr;
  logic [7:0]  load_data, mem_rdata;
  logic        load_busy, save_valid, save_done, mem_req, mem_we, autosave_req, dirty;
  logic [12:0] save_addr;
  logic [7:0]  save_data, mem_wdata;
  logic [22:0] mem_addr;

  always #5 clk = ~clk;

  megacart_nvram_io #(.FILL_BYTE(8'hFF), .IDLE_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .load_active(load_active), .load_wr(load_wr),
    .load_addr(load_addr), .load_data(load_data), .load_busy(load_busy),
    .save_start(save_start), .save_valid(save_valid), .save_ready(save_ready),
    .save_addr(save_addr), .save_data(save_data), .save_done(save_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .nv_wr(nv_wr),
    .autosave_req(autosave_req), .dirty(dirty)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Image model by file offset; SDRAM model by physical address.
  logic [7:0] img [0:8191];
  bit         written [0:8191];
  logic [7:0] sdram [int];

  int          wr_count = 0, rd_count = 0, req_cycles = 0, unstable = 0;
  bit          resp_en = 1'b1;
  bit          rs_busy = 1'b0;
  int          rs_wait = 0;
  logic [22:0] rs_addr = '0;
  logic [22:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;
  logic        last_we = 1'b0;
  int          last_busy, last_wr_delta, last_req_delta;

  function automatic bit ref_backed(input int f);
    return (f >= 32'h0400 && f < 32'h1000) || (f >= 32'h1800 && f < 32'h2000);
  endfunction

  function automatic int ref_mem_addr(input int f);
    return 32'h400000 + ((f < 32'h1000) ? f : f + 32'h8000);
  endfunction

  function automatic logic [7:0] exp_byte(input int f);
    if (!ref_backed(f)) return 8'hFF;
    if (written[f]) return img[f];
    return 8'h11;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: random 0..2 cycle latency, one-cycle ack, unwritten cells read 0x11.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) req_cycles++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req !== 1'b1 || !resp_en) begin
        rs_busy = 1'b0;
      end else begin
        if (!rs_busy) begin
          rs_busy = 1'b1;
          rs_wait = $urandom_range(0, 2);
          rs_addr = mem_addr;
        end else if (mem_addr !== rs_addr) begin
          unstable++;
        end
        if (rs_wait == 0) begin
          rs_busy   = 1'b0;
          mem_ack   = 1'b1;
          last_addr = mem_addr;
          last_we   = mem_we;
          if (mem_we) begin
            sdram[int'(mem_addr)] = mem_wdata;
            last_wdata = mem_wdata;
            wr_count++;
          end else begin
            mem_rdata = sdram.exists(int'(mem_addr)) ? sdram[int'(mem_addr)] : 8'h11;
            rd_count++;
          end
        end else begin
          rs_wait--;
        end
      end
    end
  end

  task automatic do_load(input logic [12:0] a, input logic [7:0] d, input logic with_save);
    int w0, r0, c;
    w0 = wr_count;
    r0 = req_cycles;
    load_wr = 1'b1; load_addr = a; load_data = d; save_start = with_save;
    @(negedge clk);
    load_wr = 1'b0; save_start = 1'b0;
    c = 0;
    while (load_busy === 1'b1 && c < 20) begin
      c++;
      @(negedge clk);
    end
    last_busy      = c;
    last_wr_delta  = wr_count - w0;
    last_req_delta = req_cycles - r0;
    if (ref_backed(int'(a))) begin
      img[a]     = d;
      written[a] = 1'b1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, q0, t, first, pulses;
    logic [12:0] a;
    logic [7:0]  d;
    logic [12:0] edges [6];

    reset_n = 1'b0; load_active = 1'b0; load_wr = 1'b0; load_addr = '0; load_data = '0;
    save_start = 1'b0; save_ready = 1'b0; nv_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_load_busy", 32'(load_busy), 0);
    check("rst_save_valid", 32'(save_valid), 0);
    check("rst_save_done", 32'(save_done), 0);
    check("rst_dirty", 32'(dirty), 0);
    check("rst_autosave", 32'(autosave_req), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed loads at the first byte of each backed window and two unbacked offsets.
    load_active = 1'b1;
    do_load(13'h0400, 8'h5A, 1'b0);
    check("ld400_writes", 32'(last_wr_delta), 1);
    check("ld400_addr", 32'(last_addr), 32'h400400);
    check("ld400_data", 32'(last_wdata), 32'h5A);
    check("ld400_we", 32'(last_we), 1);
    check("ld400_idle", 32'(load_busy), 0);
    do_load(13'h1800, 8'hC3, 1'b0);
    check("ld1800_addr", 32'(last_addr), 32'h409800);
    check("ld1800_data", 32'(last_wdata), 32'hC3);
    do_load(13'h0000, 8'h77, 1'b0);
    check("ld0000_nowrite", 32'(last_req_delta), 0);
    check("ld0000_busy", 32'(last_busy), 1);
    do_load(13'h1000, 8'h88, 1'b0);
    check("ld1000_nowrite", 32'(last_req_delta), 0);
    check("ld1000_busy", 32'(last_busy), 1);

    // Load and save_start together: the save must be dropped.
    r0 = req_cycles;
    do_load(13'h0010, 8'h99, 1'b1);
    repeat (4) @(negedge clk);
    check("ldsave_no_valid", 32'(save_valid), 0);
    check("ldsave_no_req", 32'(req_cycles - r0), 0);

    // Window edges, then random offsets.
    edges[0] = 13'h03FF; edges[1] = 13'h0FFF; edges[2] = 13'h17FF;
    edges[3] = 13'h1FFF; edges[4] = 13'h0401; edges[5] = 13'h1801;
    for (int i = 0; i < 66; i++) begin
      a = (i < 6) ? edges[i] : 13'($urandom_range(0, 8191));
      d = 8'($urandom);
      do_load(a, d, 1'b0);
      check("ldr_writes", 32'(last_wr_delta), ref_backed(int'(a)) ? 1 : 0);
      if (ref_backed(int'(a))) begin
        check("ldr_addr", 32'(last_addr), 32'(ref_mem_addr(int'(a))));
        check("ldr_data", 32'(last_wdata), 32'(d));
      end
      check("ldr_idle", 32'(load_busy), 0);
    end
    load_active = 1'b0;
    @(negedge clk);

    // Full save with a stall at 0x0800 and an ignored save_start mid-stream.
    r0 = rd_count;
    q0 = unstable;
    save_ready = 1'b1;
    save_start = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
    check("sv_lat1", 32'(save_valid), 0);
    @(negedge clk);
    check("sv_lat2", 32'(save_valid), 1);
    for (int f = 0; f < 8192; f++) begin
      t = 0;
      while (save_valid !== 1'b1 && t < 40) begin
        t++;
        @(negedge clk);
      end
      check("sv_valid", 32'(save_valid), 1);
      if (t >= 40) break;
      check("sv_addr", 32'(save_addr), 32'(f));
      check("sv_data", 32'(save_data), 32'(exp_byte(f)));
      if (f == 32'h0800) begin
        save_ready = 1'b0;
        t = req_cycles;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("stall_valid", 32'(save_valid), 1);
          check("stall_addr", 32'(save_addr), 32'h0800);
          check("stall_data", 32'(save_data), 32'(exp_byte(f)));
          check("stall_req", 32'(mem_req), 0);
        end
        check("stall_extra_req", 32'(req_cycles - t), 0);
        save_ready = 1'b1;
      end
      if (f == 5) save_start = 1'b1;
      @(negedge clk);
      save_start = 1'b0;
      check("sv_done", 32'(save_done), (f == 8191) ? 1 : 0);
    end
    @(negedge clk);
    check("sv_done_pulse", 32'(save_done), 0);
    check("sv_reads", 32'(rd_count - r0), 5120);
    check("sv_addr_stable", 32'(unstable - q0), 0);
    check("sv_dirty", 32'(dirty), 0);

`ifdef MEGACART_NVRAM_AUTOSAVE_EN
    nv_wr = 1'b1;
    @(negedge clk);
    nv_wr = 1'b0;
    check("as_dirty", 32'(dirty), 1);
    first = -1; pulses = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (autosave_req === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("as_first", 32'(first), 100);
    check("as_pulses", 32'(pulses), 1);
    nv_wr = 1'b1;
    @(negedge clk);
    nv_wr = 1'b0;
    first = -1; pulses = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 50) nv_wr = 1'b1;
      @(negedge clk);
      nv_wr = 1'b0;
      if (autosave_req === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("as_defer_first", 32'(first), 150);
    check("as_defer_pulses", 32'(pulses), 1);
    load_active = 1'b1;
    @(negedge clk);
    load_active = 1'b0;
    @(negedge clk);
    check("as_load_clear", 32'(dirty), 0);
`else
    nv_wr = 1'b1;
    @(negedge clk);
    nv_wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("noas_dirty", 32'(dirty), 0);
      check("noas_req", 32'(autosave_req), 0);
    end
`endif

    // Reset while a backed SAVE_RD request is outstanding.
    resp_en = 1'b0;
    save_ready = 1'b1;
    save_start = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
    t = 0;
    while (mem_req !== 1'b1 && t < 5000) begin
      t++;
      @(negedge clk);
    end
    check("rs_req_up", 32'(mem_req), 1);
    check("rs_req_addr", 32'(mem_addr), 32'h400400);
    check("rs_req_read", 32'(mem_we), 0);
`ifdef MEGACART_NVRAM_AUTOSAVE_EN
    nv_wr = 1'b1;
    @(negedge clk);
    nv_wr = 1'b0;
    check("rs_nvwr_dirty", 32'(dirty), 1);
    check("rs_req_held", 32'(mem_req), 1);
`endif
    reset_n = 1'b0;
    #1;
    check("rs_req_drop", 32'(mem_req), 0);
    check("rs_valid_drop", 32'(save_valid), 0);
    check("rs_dirty_drop", 32'(dirty), 0);
    @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rs_idle_req", 32'(mem_req), 0);
      check("rs_idle_valid", 32'(save_valid), 0);
    end
    save_start = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      t = 0;
      while (save_valid !== 1'b1 && t < 40) begin
        t++;
        @(negedge clk);
      end
      check("rs2_valid", 32'(save_valid), 1);
      check("rs2_addr", 32'(save_addr), 32'(f));
      check("rs2_data", 32'(save_data), 32'hFF);
      @(negedge clk);
    end
    save_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
